// File: rtl/clock_ratio_checker_if.sv
// Clock-ratio checker bus: measured clocks in, window results out.
// CLOCK_RATIO_DUTY_EN adds the div_clk high/low time counts.
interface clock_ratio_checker_if #(
   parameter int CW = 16
);
   logic          enable;
   logic          src_clk;
   logic          div_clk;
   logic          result_valid;
   logic          pass;
   logic [CW-1:0] src_count;
   logic          locked;
   logic          stuck;
`ifdef CLOCK_RATIO_DUTY_EN
   logic [CW-1:0] high_cnt;
   logic [CW-1:0] low_cnt;

   modport master (
      output enable, src_clk, div_clk,
      input  result_valid, pass, src_count,
      input  locked, stuck, high_cnt, low_cnt
   );
   modport slave (
      input  enable, src_clk, div_clk,
      output result_valid, pass, src_count,
      output locked, stuck, high_cnt, low_cnt
   );
`else
   modport master (
      output enable, src_clk, div_clk,
      input  result_valid, pass, src_count,
      input  locked, stuck
   );
   modport slave (
      input  enable, src_clk, div_clk,
      output result_valid, pass, src_count,
      output locked, stuck
   );
`endif
endinterface

// File: rtl/clock_ratio_checker.sv
// Checks src_clk rising edges per DEN div_clk periods equals NUM (+-TOL).
// CLOCK_RATIO_DUTY_EN adds div_clk high/low time reporting.
module clock_ratio_checker #(
   parameter int NUM      = 3,
   parameter int DEN      = 2,
   parameter int TOL      = 0,
   parameter int CW       = 16,
   parameter int LOCK_CNT = 4,
   parameter int TIMEOUT  = 1000
) (
   input logic                  clk,
   input logic                  clear_n,
   clock_ratio_checker_if.slave bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ARM  = 2'd1;
   localparam logic [1:0] S_MEAS = 2'd2;
   localparam logic [1:0] S_RPT  = 2'd3;

   localparam int            LW     = $clog2(LOCK_CNT + 1);
   localparam logic [LW-1:0] LOCK_C = LW'(LOCK_CNT);
   localparam logic [CW-1:0] NUM_C  = CW'(NUM);
   localparam logic [CW-1:0] DEN_M1 = CW'(DEN - 1);
   localparam logic [CW-1:0] TOL_C  = CW'(TOL);
   localparam logic [CW-1:0] TO_C   = CW'(TIMEOUT);
   localparam logic [CW-1:0] MAX_C  = '1;

   logic [2:0]    src_sync_q, src_sync_d;
   logic [2:0]    div_sync_q, div_sync_d;
   logic [1:0]    state_q, state_d;
   logic [CW-1:0] src_cnt_q, src_cnt_d;
   logic [CW-1:0] div_cnt_q, div_cnt_d;
   logic [CW-1:0] src_idle_q, src_idle_d;
   logic [CW-1:0] div_idle_q, div_idle_d;
   logic [CW-1:0] src_count_q, src_count_d;
   logic [LW-1:0] run_q, run_d;
   logic          pass_q, pass_d;
   logic          locked_q, locked_d;
   logic          stuck_q, stuck_d;
   logic          seen_src_q, seen_src_d;
   logic          seen_div_q, seen_div_d;

   logic          src_rise, div_rise;
   logic          active, timeout_hit, win_end, win_pass;
   logic [CW-1:0] fin_cnt, diff;

`ifdef CLOCK_RATIO_DUTY_EN
   logic [CW-1:0] hi_run_q, hi_run_d;
   logic [CW-1:0] lo_run_q, lo_run_d;
   logic [CW-1:0] hi_last_q, hi_last_d;
   logic [CW-1:0] high_cnt_q, high_cnt_d;
   logic [CW-1:0] low_cnt_q, low_cnt_d;
   logic          div_fall;
`endif

   always_comb begin
      src_sync_d = {src_sync_q[1:0], bus.src_clk};
      div_sync_d = {div_sync_q[1:0], bus.div_clk};
      src_rise   = src_sync_q[1] & ~src_sync_q[2];
      div_rise   = div_sync_q[1] & ~div_sync_q[2];

      state_d     = state_q;
      src_cnt_d   = src_cnt_q;
      div_cnt_d   = div_cnt_q;
      src_count_d = src_count_q;
      run_d       = run_q;
      pass_d      = pass_q;
      locked_d    = locked_q;
      src_idle_d  = src_idle_q;
      div_idle_d  = div_idle_q;

      active = (state_q == S_ARM) || (state_q == S_MEAS);
      timeout_hit = bus.enable && active && !stuck_q &&
                    ((src_idle_q == TO_C) || (div_idle_q == TO_C));

      fin_cnt = (src_rise && (src_cnt_q != MAX_C)) ?
                src_cnt_q + CW'(1) : src_cnt_q;
      diff     = (fin_cnt >= NUM_C) ? fin_cnt - NUM_C : NUM_C - fin_cnt;
      win_pass = (diff <= TOL_C);
      win_end  = (state_q == S_MEAS) && div_rise && (div_cnt_q == DEN_M1);

      if ((state_q == S_IDLE) || src_rise)
         src_idle_d = '0;
      else if (src_idle_q != TO_C)
         src_idle_d = src_idle_q + CW'(1);

      if ((state_q == S_IDLE) || div_rise)
         div_idle_d = '0;
      else if (div_idle_q != TO_C)
         div_idle_d = div_idle_q + CW'(1);

      // stuck releases only once both clocks have risen since it fired
      seen_src_d = stuck_q & (seen_src_q | src_rise);
      seen_div_d = stuck_q & (seen_div_q | div_rise);
      stuck_d    = stuck_q;
      if (seen_src_d && seen_div_d)
         stuck_d = 1'b0;
      else if (timeout_hit)
         stuck_d = 1'b1;

`ifdef CLOCK_RATIO_DUTY_EN
      div_fall   = div_sync_q[2] & ~div_sync_q[1];
      hi_run_d   = '0;
      lo_run_d   = '0;
      hi_last_d  = div_fall ? hi_run_q : hi_last_q;
      high_cnt_d = high_cnt_q;
      low_cnt_d  = low_cnt_q;
      if (div_sync_q[1])
         hi_run_d = (hi_run_q != MAX_C) ? hi_run_q + CW'(1) : hi_run_q;
      else
         lo_run_d = (lo_run_q != MAX_C) ? lo_run_q + CW'(1) : lo_run_q;
`endif

      if (!bus.enable) begin
         state_d = S_IDLE;
         run_d   = '0;
      end else if (timeout_hit) begin
         state_d  = S_ARM;
         run_d    = '0;
         locked_d = 1'b0;
      end else begin
         unique case (1'b1)
            (state_q == S_IDLE): state_d = S_ARM;
            (state_q == S_ARM): begin
               if (div_rise) begin
                  state_d   = S_MEAS;
                  src_cnt_d = '0;
                  div_cnt_d = '0;
               end
            end
            (state_q == S_MEAS): begin
               src_cnt_d = fin_cnt;
               div_cnt_d = div_cnt_q + CW'(div_rise);
               if (win_end) begin
                  state_d     = S_RPT;
                  src_count_d = fin_cnt;
                  pass_d      = win_pass;
                  if (!win_pass)
                     run_d = '0;
                  else if (run_q != LOCK_C)
                     run_d = run_q + LW'(1);
                  locked_d = (run_d == LOCK_C);
`ifdef CLOCK_RATIO_DUTY_EN
                  high_cnt_d = hi_last_q;
                  low_cnt_d  = lo_run_q;
`endif
               end
            end
            default: begin
               // the closing div edge already opened the next window
               state_d   = S_MEAS;
               src_cnt_d = CW'(src_rise);
               div_cnt_d = CW'(div_rise);
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         src_sync_q  <= '0;
         div_sync_q  <= '0;
         state_q     <= S_IDLE;
         src_cnt_q   <= '0;
         div_cnt_q   <= '0;
         src_idle_q  <= '0;
         div_idle_q  <= '0;
         src_count_q <= '0;
         run_q       <= '0;
         pass_q      <= 1'b0;
         locked_q    <= 1'b0;
         stuck_q     <= 1'b0;
         seen_src_q  <= 1'b0;
         seen_div_q  <= 1'b0;
`ifdef CLOCK_RATIO_DUTY_EN
         hi_run_q    <= '0;
         lo_run_q    <= '0;
         hi_last_q   <= '0;
         high_cnt_q  <= '0;
         low_cnt_q   <= '0;
`endif
      end else begin
         src_sync_q  <= src_sync_d;
         div_sync_q  <= div_sync_d;
         state_q     <= state_d;
         src_cnt_q   <= src_cnt_d;
         div_cnt_q   <= div_cnt_d;
         src_idle_q  <= src_idle_d;
         div_idle_q  <= div_idle_d;
         src_count_q <= src_count_d;
         run_q       <= run_d;
         pass_q      <= pass_d;
         locked_q    <= locked_d;
         stuck_q     <= stuck_d;
         seen_src_q  <= seen_src_d;
         seen_div_q  <= seen_div_d;
`ifdef CLOCK_RATIO_DUTY_EN
         hi_run_q    <= hi_run_d;
         lo_run_q    <= lo_run_d;
         hi_last_q   <= hi_last_d;
         high_cnt_q  <= high_cnt_d;
         low_cnt_q   <= low_cnt_d;
`endif
      end
   end

   assign bus.result_valid = (state_q == S_RPT);
   assign bus.pass         = pass_q;
   assign bus.src_count    = src_count_q;
   assign bus.locked       = locked_q;
   assign bus.stuck        = stuck_q;
`ifdef CLOCK_RATIO_DUTY_EN
   assign bus.high_cnt     = high_cnt_q;
   assign bus.low_cnt      = low_cnt_q;
`endif

endmodule
